// File: rtl/tom_kbd_ctrl.sv
// PS/2 keyboard front end: synchronizes and filters the PS/2 lines, deframes
// set-2 scancodes and turns A/D/arrow make/break codes into held left/right levels.
module tom_kbd_ctrl #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       left,
  output logic       right,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, SHIFT} rx_state_t;
  typedef enum logic [1:0] {D_IDLE, D_BRK, D_EXT, D_EXT_BRK} dec_state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          filt, filt_q;
  logic [FW-1:0] flt_cnt;
  logic          sample;

  // Sync stages reset high so a reset never fabricates a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      filt_q   <= 1'b1;
      flt_cnt  <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      filt_q   <= filt;
      if (clk_sync[1] == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        filt    <= clk_sync[1];
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign sample = filt_q & ~filt;

  rx_state_t     rx_state;
  logic [9:0]    frame;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] wdog;
  logic          frame_ok;

  // Checked while the stop bit is being sampled, so it is taken straight from the pin.
  assign frame_ok = ~frame[0] & (^frame[9:1]) & dat_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= IDLE;
      frame      <= '0;
      bit_cnt    <= '0;
      wdog       <= '0;
      code       <= 8'h00;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        IDLE: begin
          wdog <= '0;
          if (sample) begin
            frame[0] <= dat_sync[1];
            bit_cnt  <= 4'd1;
            rx_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (sample) begin
            wdog <= '0;
            if (bit_cnt == 4'd10) begin
              rx_state <= IDLE;
              if (frame_ok) begin
                code       <= frame[8:1];
                code_valid <= 1'b1;
              end else begin
                frame_err  <= 1'b1;
              end
            end else begin
              frame[bit_cnt] <= dat_sync[1];
              bit_cnt        <= bit_cnt + 4'd1;
            end
          end else if (wdog == TW'(TIMEOUT_CYCLES - 1)) begin
            frame_err <= 1'b1;
            rx_state  <= IDLE;
            wdog      <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  dec_state_t dstate, dstate_n;
  logic held_a, held_d, held_la, held_ra;
  logic held_a_n, held_d_n, held_la_n, held_ra_n;

  // Next-state decode lets left/right update the cycle after code_valid.
  always_comb begin
    dstate_n  = dstate;
    held_a_n  = held_a;
    held_d_n  = held_d;
    held_la_n = held_la;
    held_ra_n = held_ra;
    if (frame_err) begin
      dstate_n = D_IDLE;
    end else if (code_valid) begin
      case (dstate)
        D_IDLE: begin
          case (code)
            8'hF0: dstate_n = D_BRK;
            8'hE0: dstate_n = D_EXT;
            8'h1C: held_a_n = 1'b1;
            8'h23: held_d_n = 1'b1;
            8'h00, 8'hFF: begin
              held_a_n  = 1'b0;
              held_d_n  = 1'b0;
              held_la_n = 1'b0;
              held_ra_n = 1'b0;
            end
            default: ;
          endcase
        end
        D_BRK: begin
          if (code != 8'hF0) dstate_n = D_IDLE;
          if (code == 8'h1C) held_a_n = 1'b0;
          if (code == 8'h23) held_d_n = 1'b0;
        end
        D_EXT: begin
          case (code)
            8'hF0: dstate_n = D_EXT_BRK;
            8'hE0: dstate_n = D_EXT;
            default: dstate_n = D_IDLE;
          endcase
          if (code == 8'h6B) held_la_n = 1'b1;
          if (code == 8'h74) held_ra_n = 1'b1;
        end
        D_EXT_BRK: begin
          dstate_n = D_IDLE;
          if (code == 8'h6B) held_la_n = 1'b0;
          if (code == 8'h74) held_ra_n = 1'b0;
        end
        default: dstate_n = D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dstate  <= D_IDLE;
      held_a  <= 1'b0;
      held_d  <= 1'b0;
      held_la <= 1'b0;
      held_ra <= 1'b0;
      left    <= 1'b0;
      right   <= 1'b0;
    end else begin
      dstate  <= dstate_n;
      held_a  <= held_a_n;
      held_d  <= held_d_n;
      held_la <= held_la_n;
      held_ra <= held_ra_n;
      left    <= held_a_n | held_la_n;
      right   <= held_d_n | held_ra_n;
    end
  end

endmodule

// File: tb/tb_tom_kbd_ctrl.sv
// Bench for tom_kbd_ctrl: directed vector table, timeout/glitch/reset sequences,
// then random scancode streams checked against a key-table reference model.
`timescale 1ns/1ps
module tb_tom_kbd_ctrl;
  localparam int FL = 8;
  localparam int TO = 2000;
  localparam int H  = 20;

  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic left, right, code_valid, frame_err;
  logic [7:0] code;

  tom_kbd_ctrl #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .left(left), .right(right), .code(code),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  int cv_cnt = 0, fe_cnt = 0;
  logic [7:0] cv_code;
  logic l_at_cv = 0, l_next = 0, r_next = 0;
  bit pend = 0;
  always @(negedge clk) begin
    if (code_valid) begin
      cv_cnt++; cv_code = code; l_at_cv = left; pend = 1;
    end else if (pend) begin
      l_next = left; r_next = right; pend = 0;
    end
    if (frame_err) fe_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] fr, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = fr[i];
      if (glitch) begin
        wait_clk(H/2); ps2_clk = 1'b0; wait_clk(2); ps2_clk = 1'b1; wait_clk(H/2 - 2);
      end else wait_clk(H);
      ps2_clk = 1'b0;
      if (glitch) begin
        wait_clk(H/2); ps2_clk = 1'b1; wait_clk(2); ps2_clk = 1'b0; wait_clk(H/2 - 2);
      end else wait_clk(H);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad);
    logic par;
    par = bad ? (^b) : ~(^b);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bad, input bit glitch);
    cv_cnt = 0; fe_cnt = 0;
    send_bits(mk_frame(b, bad), 11, glitch);
    ps2_data = 1'b1;
    wait_clk(H + 5);
  endtask

  // Reference model: held flags indexed by {extended, scancode}.
  bit held[512];
  bit m_ext, m_brk;
  logic [7:0] m_code;

  function automatic bit m_left();  return held[9'h01C] | held[9'h16B]; endfunction
  function automatic bit m_right(); return held[9'h023] | held[9'h174]; endfunction
  function automatic bit is_key(input logic [7:0] b, input bit ext);
    return ext ? (b == 8'h6B || b == 8'h74) : (b == 8'h1C || b == 8'h23);
  endfunction

  task automatic model_reset();
    foreach (held[i]) held[i] = 1'b0;
    m_ext = 0; m_brk = 0; m_code = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_code = b;
    if (!m_ext && !m_brk) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'h00 || b == 8'hFF) foreach (held[i]) held[i] = 1'b0;
      else if (is_key(b, 0)) held[{1'b0, b}] = 1'b1;
    end else if (!m_ext) begin
      if (b != 8'hF0) begin
        if (is_key(b, 0)) held[{1'b0, b}] = 1'b0;
        m_brk = 0;
      end
    end else if (!m_brk) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) begin
        if (is_key(b, 1)) held[{1'b1, b}] = 1'b1;
        m_ext = 0;
      end
    end else begin
      if (is_key(b, 1)) held[{1'b1, b}] = 1'b0;
      m_ext = 0; m_brk = 0;
    end
  endtask

  typedef struct {
    logic [7:0] b;
    bit bad, cv, fe, l, r;
    logic [7:0] c;
  } vec_t;
  vec_t tbl[$];

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; wait_clk(3); rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl.push_back('{8'h1C, 0, 1, 0, 1, 0, 8'h1C});
    tbl.push_back('{8'hF0, 0, 1, 0, 1, 0, 8'hF0});
    tbl.push_back('{8'h1C, 0, 1, 0, 0, 0, 8'h1C});
    tbl.push_back('{8'hE0, 0, 1, 0, 0, 0, 8'hE0});
    tbl.push_back('{8'h74, 0, 1, 0, 0, 1, 8'h74});
    tbl.push_back('{8'h1C, 0, 1, 0, 1, 1, 8'h1C});
    tbl.push_back('{8'hE0, 0, 1, 0, 1, 1, 8'hE0});
    tbl.push_back('{8'hF0, 0, 1, 0, 1, 1, 8'hF0});
    tbl.push_back('{8'h74, 0, 1, 0, 1, 0, 8'h74});
    tbl.push_back('{8'h23, 1, 0, 1, 1, 0, 8'h74});
    tbl.push_back('{8'h23, 0, 1, 0, 1, 1, 8'h23});
    tbl.push_back('{8'hE0, 0, 1, 0, 1, 1, 8'hE0});
    tbl.push_back('{8'h74, 0, 1, 0, 1, 1, 8'h74});
    tbl.push_back('{8'hFF, 0, 1, 0, 0, 0, 8'hFF});
    tbl.push_back('{8'hF0, 0, 1, 0, 0, 0, 8'hF0});
    tbl.push_back('{8'h1C, 1, 0, 1, 0, 0, 8'hF0});
    tbl.push_back('{8'h1C, 0, 1, 0, 1, 0, 8'h1C});
    tbl.push_back('{8'hF0, 0, 1, 0, 1, 0, 8'hF0});
    tbl.push_back('{8'h1C, 0, 1, 0, 0, 0, 8'h1C});

    wait_clk(4);
    chk("rst_left", left, 0);  chk("rst_right", right, 0);
    chk("rst_code", code, 0);  chk("rst_cv", code_valid, 0);
    chk("rst_fe", frame_err, 0);
    rst = 1'b0;
    wait_clk(20);

    foreach (tbl[i]) begin
      send_byte(tbl[i].b, tbl[i].bad, 0);
      chk($sformatf("tbl%0d_cv", i), cv_cnt, tbl[i].cv);
      chk($sformatf("tbl%0d_fe", i), fe_cnt, tbl[i].fe);
      chk($sformatf("tbl%0d_code", i), code, tbl[i].c);
      chk($sformatf("tbl%0d_left", i), left, tbl[i].l);
      chk($sformatf("tbl%0d_right", i), right, tbl[i].r);
      if (i == 0) begin
        chk("lat_left_at_cv", l_at_cv, 0);
        chk("lat_left_next", l_next, 1);
      end
    end

    // Partial frame then silence: watchdog must abort exactly once.
    cv_cnt = 0; fe_cnt = 0;
    send_bits(mk_frame(8'h55, 0), 5, 0);
    ps2_data = 1'b1;
    for (int n = 0; n < TO + 500 && fe_cnt == 0; n++) wait_clk(1);
    wait_clk(100);
    chk("timeout_fe", fe_cnt, 1);
    chk("timeout_cv", cv_cnt, 0);
    send_byte(8'hE0, 0, 0);
    send_byte(8'h6B, 0, 0);
    chk("post_to_code", code, 8'h6B);
    chk("post_to_left", left, 1);
    chk("post_to_right", right, 0);

    // Short glitches on ps2_clk must not add or drop bits.
    send_byte(8'hE0, 0, 1);
    send_byte(8'hF0, 0, 1);
    send_byte(8'h6B, 0, 1);
    chk("glitch_rel_left", left, 0);
    chk("glitch_rel_code", code, 8'h6B);
    send_byte(8'h1C, 0, 1);
    chk("glitch_cv", cv_cnt, 1);
    chk("glitch_fe", fe_cnt, 0);
    chk("glitch_code", code, 8'h1C);
    chk("glitch_left", left, 1);

    // Reset in the middle of a frame.
    send_bits(mk_frame(8'h23, 0), 5, 0);
    do_reset();
    ps2_data = 1'b1;
    wait_clk(1);
    chk("midrst_left", left, 0);  chk("midrst_right", right, 0);
    chk("midrst_code", code, 0);
    wait_clk(H * 2);
    send_byte(8'h23, 0, 0);
    chk("midrst_next_cv", cv_cnt, 1);
    chk("midrst_next_code", code, 8'h23);
    chk("midrst_next_right", right, 1);

    // Random streams against the reference model.
    do_reset();
    model_reset();
    wait_clk(H);
    for (int k = 0; k < 40; k++) begin
      logic [7:0] b;
      bit bad;
      int sel;
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1: b = 8'h1C;
        2, 3: b = 8'h23;
        4: b = 8'h6B;
        5: b = 8'h74;
        6, 7: b = 8'hE0;
        8, 9: b = 8'hF0;
        10: b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        default: b = 8'($urandom);
      endcase
      bad = ($urandom_range(0, 9) == 0);
      send_byte(b, bad, 0);
      if (bad) begin
        m_ext = 0; m_brk = 0;
      end else model_byte(b);
      chk($sformatf("rnd%0d_cv", k), cv_cnt, bad ? 0 : 1);
      chk($sformatf("rnd%0d_fe", k), fe_cnt, bad ? 1 : 0);
      chk($sformatf("rnd%0d_code", k), code, m_code);
      chk($sformatf("rnd%0d_left", k), left, m_left());
      chk($sformatf("rnd%0d_right", k), right, m_right());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
